// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM state
// encoding, parity selection codes and a frame-length helper.
package uart_pkg;

  // Transmitter states; explicit 3-bit encodings keep the legacy numbering.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;

  // Parity selection codes for the PARITY parameter.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Number of serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    int unsigned n;
    n = 1 + data_w + stop_bits;
    if (parity != PAR_NONE) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the
// last cycle of each period. Held at zero while clr is asserted.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     TW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0]   LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and restart; never runs past the terminal value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, registered serial
// output, idle-high line, LSB first, optional parity, 1 or 2 stop bits.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_param
  import uart_pkg::tx_state_e, uart_pkg::IDLE, uart_pkg::START,
         uart_pkg::DATA, uart_pkg::STOP, uart_pkg::BREAK,
         uart_pkg::PAR_NONE, uart_pkg::PAR_EVEN;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              txd,
  output logic              tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic              brk
`endif
);

  localparam int unsigned   IW        = $clog2(DATA_W) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0]     idx;
  logic              par_bit;
  logic              tick;
  logic              clr;

`ifdef UART_TX_BREAK_EN
  localparam logic [IW-1:0] MAB_LAST = IW'(1);
  logic mab;
`endif

  // Hold the bit timer at zero whenever no timed bit is being produced.
  always_comb begin
    clr = (state == IDLE);
`ifdef UART_TX_BREAK_EN
    if ((state == BREAK) && !mab) clr = 1'b1;
`endif
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Frame sequencer; txd, tx_rdy and tx_done are all driven from registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '1;
      idx     <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
      tx_rdy  <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_BREAK_EN
      mab     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state  <= BREAK;
            txd    <= 1'b0;
            tx_rdy <= 1'b0;
            mab    <= 1'b0;
          end else
`endif
          if (tx_vld) begin
            shift   <= din;
            par_bit <= (PARITY == PAR_EVEN) ? ^din : ~^din;
            idx     <= '0;
            txd     <= 1'b0;
            tx_rdy  <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shift[0];
            shift <= {1'b1, shift[DATA_W-1:1]};
            idx   <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= uart_pkg::PARITY;
                txd   <= par_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              idx   <= idx + 1'b1;
              txd   <= shift[0];
              shift <= {1'b1, shift[DATA_W-1:1]};
            end
          end
        end

        uart_pkg::PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= 1'b1;
            idx   <= '0;
          end
        end

        STOP: begin
          if (tick) begin
            if (idx == LAST_STOP) begin
              state   <= IDLE;
              idx     <= '0;
              tx_rdy  <= 1'b1;
              tx_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_BREAK_EN
        // Break: line low while brk is held, then two bit periods of mark
        // (counted in idx) before the transmitter reports ready again.
        BREAK: begin
          if (!mab) begin
            if (!brk) begin
              mab <= 1'b1;
              txd <= 1'b1;
              idx <= '0;
            end
          end else if (tick) begin
            if (idx == MAB_LAST) begin
              state  <= IDLE;
              mab    <= 1'b0;
              idx    <= '0;
              tx_rdy <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`endif

        default: begin
          state  <= IDLE;
          txd    <= 1'b1;
          tx_rdy <= 1'b1;
          idx    <= '0;
        end
      endcase
    end
  end

endmodule
